timer_ctrl: RTL
===============

# timer_ctrl

Run-control stage for the timer counter chain. Sits directly upstream of the cascaded 4-bit synchronous counters: it generates their count-enable (`cten`) from a programmable prescaler, issues the clear that starts each run, and consumes the last stage's terminal count (`tc`) to detect expiry. It supports one-shot and periodic modes, with pause and stop control.

## Interface
- `PS_W`, default 8: prescaler divisor width.
- `EXP_W`, default 8: expiry-counter width.

Ports:
- `clk`  in  1  system clock; rising-edge.
- `clr`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse; begin a new run, also restarts a run in progress.
- `stop`  in  1  pulse; abort the run.
- `pause`  in  1  level; freeze the prescaler while high.
- `mode`  in  1  0 = one-shot, 1 = periodic; sampled at `start`.
- `ps_div`  in  `PS_W`  sets the `cten` period to `ps_div`+1 clocks; sampled at `start`.
- `tc`  in  1  terminal count from the last counter stage (already qualified by `cten`).
- `cten`  out  1  registered count-enable pulse to every counter stage.
- `cnt_clr`  out  1  registered active-low clear to every counter stage.
- `busy`  out  1  high in LOAD, RUN and PAUSE.
- `done`  out  1  one-cycle expiry pulse.
- `exp_cnt`  out  `EXP_W`  saturating count of expiries in this run.

## Operation
- States: IDLE, LOAD, RUN, PAUSE.
- **IDLE:**
  - `start` → LOAD.
  - Latch `mode` and `ps_div`.
- **LOAD:** held for one cycle.
  - `cnt_clr`=0.
  - Prescaler count `ps_cnt`=0.
  - `exp_cnt`=0.
  - Next state: RUN.
- **RUN:**
  - `ps_cnt` increments every cycle and wraps to 0 after reaching the latched `ps_div`.
  - `cten` is registered high in the cycle after `ps_cnt`==`ps_div`.
- **Pause:**
  - RUN with `pause`=1 → PAUSE. `ps_cnt` holds and no new `cten` is issued.
  - A `cten` pulse already registered still completes.
  - PAUSE with `pause`=0 → RUN, resuming from the held `ps_cnt`.
- **Expiry:** the hit condition is `tc_hit` = `cten` & `tc`, sampled in RUN or PAUSE.
  - `done` is registered high for one cycle.
  - One-shot: next state IDLE.
  - Periodic: stay in RUN. The counters wrap to 0 on the same edge, with no reload.
- **Stop:** `stop` in LOAD, RUN or PAUSE → IDLE.
  - `cten` goes low; the counters hold their value.
- **Priority:**
  - `stop` beats `start`.
  - `start` beats `pause`.
  - `start` while busy → LOAD (restart).
  - If `tc_hit` and `stop` occur together, `done` still pulses and the next state is IDLE.
- **Prescaler arithmetic:**
  - `ps_div`=0 gives `cten` on every cycle.
  - `ps_cnt` is `PS_W` bits wide and never exceeds the latched `ps_div`.
- **Reset values:**
  - state IDLE
  - `cten`=0
  - `cnt_clr`=0, so the counters are held clear during reset
  - `busy`=0
  - `done`=0
  - `exp_cnt`=0
  - `ps_cnt`=0
- **Reset during a run:** the block returns immediately to the reset values; there is no recovery state.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `start` in cycle 0:
  - LOAD in cycle 1, with `cnt_clr`=0 and `busy`=1.
  - RUN from cycle 2.
  - First `cten` in cycle 3+`ps_div`.
  - Subsequent `cten` pulses every `ps_div`+1 cycles.
- `cnt_clr` returns high in the cycle after reset release and stays high except during LOAD.
- `done` is high in the cycle after `tc_hit`.
  - One-shot: `busy` falls in that same cycle.
- One-shot run length for N counter stages is 16^N `cten` pulses.

## Configuration
- `TIMER_CTRL_EXPCNT_EN` defined:
  - `exp_cnt` increments on each `done` and saturates at 2^`EXP_W`−1.
  - It clears in LOAD and holds in IDLE.
- `TIMER_CTRL_EXPCNT_EN` not defined:
  - The `exp_cnt` port remains but is tied to 0; no expiry-count register is generated.

## Structure
- Package `timer_pkg`:
  - typedef `timer_state_e` {IDLE, LOAD, RUN, PAUSE}
  - constants `MODE_ONESHOT`=0 and `MODE_PERIODIC`=1
- Sub-module `timer_prescaler`:
  - Contains the `ps_cnt` register, the latched divisor and the `cten` register.
  - Inputs: `run_en`, `load`.
- The FSM, expiry logic and `exp_cnt` live in `timer_ctrl`.

## Test plan
Bench: one 4-bit counter stage downstream.
- One-shot, `ps_div`=3, `start` in cycle 0 → `cten` in cycles 6, 10, …, 66; `done` in cycle 67; `busy`=0 from cycle 67; counter output reads 0.
- Periodic, `ps_div`=0 → `done` every 16 cycles starting in cycle 19. With `TIMER_CTRL_EXPCNT_EN`, `exp_cnt` reads 1, 2, 3, …, saturating at 255.
- `pause` high for 10 cycles mid-run, `ps_div`=3 → the one-shot `done` is delayed by exactly 10 cycles and the counter does not advance while paused.
- `stop` and `start` in the same cycle during RUN → IDLE, `cten` stays 0, the counter holds its value and no LOAD occurs.
- `clr` asserted mid-run with counter at 7 → `cten`=0, `cnt_clr`=0, `busy`=0 immediately; the counter reads 0; after release, `start` gives normal cycle-0 timing.
- `start` during RUN at counter 9 → `cnt_clr` low in the next cycle and the counter is 0; the full 16-`cten` run then repeats.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the timer run-control stage.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        PAUSE = 2'd3
    } timer_state_e;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_prescaler.sv
// Programmable prescaler: latches the divisor on load and emits a registered
// count-enable pulse every div+1 enabled cycles.
module timer_prescaler #(
    parameter int PS_W = 8
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            load,
    input  logic [PS_W-1:0] div,
    input  logic            run_en,
    output logic            cten
);

    logic [PS_W-1:0] div_reg;
    logic [PS_W-1:0] ps_cnt_reg;
    logic            cten_reg;
    logic            wrap;

    assign wrap = (ps_cnt_reg == div_reg);
    assign cten = cten_reg;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            div_reg    <= '0;
            ps_cnt_reg <= '0;
            cten_reg   <= 1'b0;
        end else if (load) begin
            div_reg    <= div;
            ps_cnt_reg <= '0;
            cten_reg   <= 1'b0;
        end else begin
            // When run_en drops (pause/stop) the count freezes; a pulse already
            // registered is left to complete on its own.
            cten_reg <= run_en & wrap;
            if (run_en) begin
                ps_cnt_reg <= wrap ? '0 : ps_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Run-control FSM for the cascaded counter chain: prescaled count-enable,
// run clear, expiry detection. Define TIMER_CTRL_EXPCNT_EN for the expiry counter.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int PS_W  = 8,
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode,
    input  logic [PS_W-1:0]  ps_div,
    input  logic             tc,
    output logic             cten,
    output logic             cnt_clr,
    output logic             busy,
    output logic             done,
    output logic [EXP_W-1:0] exp_cnt
);

    timer_state_e state_reg, state_next;
    logic mode_reg;
    logic cnt_clr_reg, cnt_clr_next;
    logic busy_reg, busy_next;
    logic done_reg, done_next;
    logic active, tc_hit, load, run_en;

    assign active = (state_reg == RUN) || (state_reg == PAUSE);
    assign tc_hit = active & cten & tc;
    assign load   = (state_next == LOAD);
    assign run_en = active && (state_next == RUN);

    timer_prescaler #(.PS_W(PS_W)) u_prescaler (
        .clk    (clk),
        .clr    (clr),
        .load   (load),
        .div    (ps_div),
        .run_en (run_en),
        .cten   (cten)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg   <= IDLE;
            mode_reg    <= MODE_ONESHOT;
            cnt_clr_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_clr_reg <= cnt_clr_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            if (load) begin
                mode_reg <= mode;
            end
        end
    end

    // Priority: stop > start (restart) > one-shot expiry > pause.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start && !stop) state_next = LOAD;
            end
            LOAD: begin
                if (stop)       state_next = IDLE;
                else if (start) state_next = LOAD;
                else            state_next = RUN;
            end
            default: begin
                if (stop)                                     state_next = IDLE;
                else if (start)                               state_next = LOAD;
                else if (tc_hit && mode_reg == MODE_ONESHOT)  state_next = IDLE;
                else if (pause)                               state_next = PAUSE;
                else                                          state_next = RUN;
            end
        endcase
    end

    always_comb begin
        cnt_clr_next = (state_next != LOAD);
        busy_next    = (state_next != IDLE);
        done_next    = tc_hit;
    end

    assign cnt_clr = cnt_clr_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

`ifdef TIMER_CTRL_EXPCNT_EN
    logic [EXP_W-1:0] exp_cnt_reg;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            exp_cnt_reg <= '0;
        end else if (load) begin
            exp_cnt_reg <= '0;
        end else if (tc_hit && (exp_cnt_reg != {EXP_W{1'b1}})) begin
            exp_cnt_reg <= exp_cnt_reg + 1'b1;
        end
    end

    assign exp_cnt = exp_cnt_reg;
`else
    assign exp_cnt = '0;
`endif

endmodule
